// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction between EXE and WB, formats load
// data and multiplier products, and exposes bypass/hazard/exception status.
module mem_stage #(
  parameter int EXC_W   = 16,
  parameter int ES2MS_W = 78 + EXC_W,
  parameter int MS2WS_W = 70 + EXC_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               es2ms_valid,
  output logic               ms_allowin,
  input  logic [ES2MS_W-1:0] es2ms_bus,
  input  logic               res_from_mul,
  input  logic [67:0]        mul_result,
  input  logic [31:0]        data_sram_rdata,
  input  logic               ws_allowin,
  output logic               ms2ws_valid,
  output logic [MS2WS_W-1:0] ms2ws_bus,
  output logic [37:0]        mem_forward_zip,
  output logic               ms_block,
  output logic               ms_ex,
  output logic               ms_csr_re,
  input  logic               wb_ex
);

  logic               ms_valid, fresh, hold_valid;
  logic [ES2MS_W-1:0] bus_r;
  logic               rfm_r;
  logic [31:0]        rdata_hold;
  logic [63:0]        mul_hold;
  logic               latch;

  logic [31:0]      pc, alu_result;
  logic [2:0]       mul_op;
  logic [4:0]       load_op, dest;
  logic             gr_we;
  logic [EXC_W-1:0] except_zip;

  logic [31:0] rdata, ld_res, mul_res, final_result;
  logic [63:0] product;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ms_rf_we;
  logic        unused_mul_hi;

  assign unused_mul_hi = ^mul_result[67:64];

  assign ms_allowin  = ~ms_valid | ws_allowin;
  assign ms2ws_valid = ms_valid;
  assign latch       = es2ms_valid & ms_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid   <= 1'b0;
      fresh      <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      if (wb_ex)           ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es2ms_valid;
      fresh <= latch;
      if (latch)      hold_valid <= 1'b0;
      else if (fresh) hold_valid <= 1'b1;
    end
  end

  // Data registers carry no reset; they are only observed while ms_valid=1.
  always_ff @(posedge clk) begin
    if (latch) begin
      bus_r <= es2ms_bus;
      rfm_r <= res_from_mul;
    end
    if (fresh) begin
      rdata_hold <= data_sram_rdata;
      mul_hold   <= mul_result[63:0];
    end
  end

  assign {pc, mul_op, alu_result, load_op, dest, gr_we, except_zip} = bus_r;

  // Live inputs are only valid in the first MEM cycle; afterwards use the copies.
  assign rdata   = fresh ? data_sram_rdata : rdata_hold;
  assign product = fresh ? mul_result[63:0] : mul_hold;

  always_comb begin
    ld_byte = rdata[7:0];
    case (alu_result[1:0])
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
  end

  assign ld_half = alu_result[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_res = 32'd0;
    if (load_op[0]) ld_res = {{24{ld_byte[7]}}, ld_byte};
    if (load_op[3]) ld_res = {24'd0, ld_byte};
    if (load_op[1]) ld_res = {{16{ld_half[15]}}, ld_half};
    if (load_op[4]) ld_res = {16'd0, ld_half};
    if (load_op[2]) ld_res = rdata;
  end

  always_comb begin
    mul_res = 32'd0;
    if (mul_op[0])             mul_res = product[31:0];
    if (mul_op[1] | mul_op[2]) mul_res = product[63:32];
  end

  always_comb begin
    final_result = alu_result;
    if (|load_op)   final_result = ld_res;
    else if (rfm_r) final_result = mul_res;
  end

  // Bit 1 of except_zip marks a CSR read, not an exception.
  assign ms_ex     = ms_valid & |(except_zip & ~EXC_W'(2));
  assign ms_csr_re = ms_valid & except_zip[1];
  assign ms_rf_we  = ms_valid & gr_we & ~ms_ex;
  assign ms_block  = ms_valid & |load_op & ~fresh & ~hold_valid;

  assign ms2ws_bus       = {pc, final_result, dest, gr_we, except_zip};
  assign mem_forward_zip = {ms_rf_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed + randomized bench for mem_stage against a behavioural result model.
module tb_mem_stage;
  localparam int EXC_W   = 16;
  localparam int ES2MS_W = 78 + EXC_W;
  localparam int MS2WS_W = 70 + EXC_W;

  logic               clk = 1'b0;
  logic               resetn;
  logic               es2ms_valid;
  logic               ms_allowin;
  logic [ES2MS_W-1:0] es2ms_bus;
  logic               res_from_mul;
  logic [67:0]        mul_result;
  logic [31:0]        data_sram_rdata;
  logic               ws_allowin;
  logic               ms2ws_valid;
  logic [MS2WS_W-1:0] ms2ws_bus;
  logic [37:0]        mem_forward_zip;
  logic               ms_block, ms_ex, ms_csr_re, wb_ex;

  int total = 0, passed = 0, fails = 0;

  mem_stage #(.EXC_W(EXC_W), .ES2MS_W(ES2MS_W), .MS2WS_W(MS2WS_W)) dut (
    .clk(clk), .resetn(resetn), .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
    .es2ms_bus(es2ms_bus), .res_from_mul(res_from_mul), .mul_result(mul_result),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin),
    .ms2ws_valid(ms2ws_valid), .ms2ws_bus(ms2ws_bus), .mem_forward_zip(mem_forward_zip),
    .ms_block(ms_block), .ms_ex(ms_ex), .ms_csr_re(ms_csr_re), .wb_ex(wb_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the architecture says the instruction writes back.
  function automatic logic [31:0] model(input logic [4:0] lop, input logic [2:0] mop,
                                        input logic rfm, input logic [31:0] alu,
                                        input logic [31:0] rdata, input logic [63:0] prod);
    logic [31:0] b, h;
    b = (rdata >> (int'(alu[1:0]) * 8)) & 32'hFF;
    h = (rdata >> (int'(alu[1]) * 16)) & 32'hFFFF;
    if (lop != 5'd0) begin
      case (lop)
        5'b00001: return b[7]  ? (b | 32'hFFFF_FF00) : b;
        5'b01000: return b;
        5'b00010: return h[15] ? (h | 32'hFFFF_0000) : h;
        5'b10000: return h;
        default:  return rdata;
      endcase
    end
    if (rfm) return (mop == 3'b001) ? prod[31:0] : prod[63:32];
    return alu;
  endfunction

  function automatic logic [ES2MS_W-1:0] rnd_bus();
    return ES2MS_W'({$urandom, $urandom, $urandom});
  endfunction

  // One instruction through MEM with `stall` WB stall cycles.
  task automatic one(input string tag, input logic [31:0] pc, input logic [31:0] alu,
                     input logic [31:0] rdata, input logic [31:0] rdata_late,
                     input logic [2:0] mop, input logic [4:0] lop, input logic [4:0] dest,
                     input logic gr_we, input logic rfm, input logic [63:0] prod,
                     input int stall);
    logic [31:0] er;
    logic [MS2WS_W-1:0] eb;
    er = model(lop, mop, rfm, alu, rdata, prod);
    eb = {pc, er, dest, gr_we, 16'h0};
    ws_allowin = 1'b1;
    es2ms_valid = 1'b1;
    es2ms_bus = {pc, mop, alu, lop, dest, gr_we, 16'h0};
    res_from_mul = rfm;
    cyc();
    es2ms_valid = 1'b0;
    es2ms_bus = rnd_bus();
    res_from_mul = 1'($urandom);
    data_sram_rdata = rdata;
    mul_result = {4'h0, prod};
    ws_allowin = (stall == 0);
    #1;
    chk({tag, ".valid"}, 128'(ms2ws_valid), 128'(1'b1));
    chk({tag, ".bus"}, 128'(ms2ws_bus), 128'(eb));
    chk({tag, ".fwd"}, 128'(mem_forward_zip), 128'({gr_we, dest, er}));
    for (int s = 0; s < stall; s++) begin
      cyc();
      data_sram_rdata = rdata_late;
      mul_result = {$urandom, $urandom, $urandom};
      if (s == stall - 1) ws_allowin = 1'b1;
      #1;
      chk({tag, ".stall_bus"}, 128'(ms2ws_bus), 128'(eb));
      chk({tag, ".stall_block"}, 128'(ms_block), 128'(1'b0));
      chk({tag, ".stall_valid"}, 128'(ms2ws_valid), 128'(1'b1));
    end
    cyc();
    #1;
    chk({tag, ".drained"}, 128'(ms2ws_valid), 128'(1'b0));
  endtask

  task automatic rnd_kind(output logic [4:0] lop, output logic [2:0] mop, output logic rfm);
    int k;
    k = $urandom_range(0, 8);
    mop = 3'b001 << $urandom_range(0, 2);
    rfm = 1'($urandom);
    lop = 5'd0;
    if (k <= 4) lop = 5'b00001 << k;
    else if (k <= 7) begin rfm = 1'b1; mop = 3'b001 << (k - 5); end
    else rfm = 1'b0;
  endtask

  localparam int N = 20;
  logic [31:0] q_pc[N], q_alu[N], q_rd[N];
  logic [63:0] q_prod[N];
  logic [4:0]  q_lop[N], q_dest[N];
  logic [2:0]  q_mop[N];
  logic        q_rfm[N], q_we[N];

  initial begin
    resetn = 1'b0; es2ms_valid = 1'b0; es2ms_bus = '0; res_from_mul = 1'b0;
    mul_result = '0; data_sram_rdata = '0; ws_allowin = 1'b1; wb_ex = 1'b0;
    #3;
    chk("rst.valid", 128'(ms2ws_valid), 128'(1'b0));
    chk("rst.allowin", 128'(ms_allowin), 128'(1'b1));
    chk("rst.block", 128'(ms_block), 128'(1'b0));
    chk("rst.ex", 128'(ms_ex), 128'(1'b0));
    chk("rst.csr", 128'(ms_csr_re), 128'(1'b0));
    chk("rst.rfwe", 128'(mem_forward_zip[37]), 128'(1'b0));
    #9 resetn = 1'b1;

    // Directed load / mul vectors
    one("ldb",  32'h100, 32'h1003, 32'h80FF_1234, 32'h0, 3'b001, 5'b00001, 5'd3, 1'b1, 1'b0, 64'h0, 0);
    one("ldbu", 32'h104, 32'h1003, 32'h80FF_1234, 32'h0, 3'b001, 5'b01000, 5'd4, 1'b1, 1'b0, 64'h0, 0);
    one("ldh",  32'h108, 32'h2002, 32'h8001_7FFF, 32'h0, 3'b001, 5'b00010, 5'd5, 1'b1, 1'b0, 64'h0, 1);
    one("ldw_stall", 32'h10C, 32'h3000, 32'h0123_4567, 32'hDEAD_BEEF, 3'b001, 5'b00100, 5'd6, 1'b1, 1'b0, 64'h0, 3);
    one("mulhwu", 32'h110, 32'h0, 32'h0, 32'h0, 3'b100, 5'd0, 5'd7, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 2);
    one("mulw", 32'h114, 32'h0, 32'h0, 32'h0, 3'b001, 5'd0, 5'd8, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 0);

    // Random single instructions with random stalls
    for (int i = 0; i < 12; i++) begin
      logic [4:0] lop; logic [2:0] mop; logic rfm;
      rnd_kind(lop, mop, rfm);
      one("rnd", $urandom, $urandom, $urandom, $urandom, mop, lop, 5'($urandom),
          1'($urandom), rfm, {$urandom, $urandom}, $urandom_range(0, 3));
    end

    // Back-to-back stream, WB always ready: each result must use live data
    for (int i = 0; i < N; i++) begin
      rnd_kind(q_lop[i], q_mop[i], q_rfm[i]);
      q_pc[i] = $urandom; q_alu[i] = $urandom; q_rd[i] = $urandom;
      q_prod[i] = {$urandom, $urandom}; q_dest[i] = 5'($urandom); q_we[i] = 1'($urandom);
    end
    ws_allowin = 1'b1;
    es2ms_valid = 1'b1;
    es2ms_bus = {q_pc[0], q_mop[0], q_alu[0], q_lop[0], q_dest[0], q_we[0], 16'h0};
    res_from_mul = q_rfm[0];
    cyc();
    for (int i = 1; i <= N; i++) begin
      if (i < N) begin
        es2ms_bus = {q_pc[i], q_mop[i], q_alu[i], q_lop[i], q_dest[i], q_we[i], 16'h0};
        res_from_mul = q_rfm[i];
      end else begin
        es2ms_valid = 1'b0;
        es2ms_bus = rnd_bus();
      end
      data_sram_rdata = q_rd[i-1];
      mul_result = {4'h0, q_prod[i-1]};
      #1;
      chk("b2b.valid", 128'(ms2ws_valid), 128'(1'b1));
      chk("b2b.bus", 128'(ms2ws_bus),
          128'({q_pc[i-1], model(q_lop[i-1], q_mop[i-1], q_rfm[i-1], q_alu[i-1], q_rd[i-1], q_prod[i-1]),
                q_dest[i-1], q_we[i-1], 16'h0}));
      cyc();
    end
    #1;
    chk("b2b.drained", 128'(ms2ws_valid), 128'(1'b0));

    // Exception and CSR-read side-band
    es2ms_valid = 1'b1; ws_allowin = 1'b0;
    es2ms_bus = {32'h200, 3'b001, 32'h55, 5'd0, 5'd9, 1'b1, 16'h0001};
    res_from_mul = 1'b0;
    cyc();
    es2ms_valid = 1'b0;
    #1;
    chk("exc.ms_ex", 128'(ms_ex), 128'(1'b1));
    chk("exc.rfwe", 128'(mem_forward_zip[37]), 128'(1'b0));
    chk("exc.csr", 128'(ms_csr_re), 128'(1'b0));
    ws_allowin = 1'b1; es2ms_valid = 1'b1;
    es2ms_bus = {32'h204, 3'b001, 32'h66, 5'd0, 5'd10, 1'b1, 16'h0002};
    cyc();
    es2ms_valid = 1'b0;
    #1;
    chk("csr.ms_ex", 128'(ms_ex), 128'(1'b0));
    chk("csr.csr_re", 128'(ms_csr_re), 128'(1'b1));
    chk("csr.rfwe", 128'(mem_forward_zip[37]), 128'(1'b1));
    cyc();

    // Flush in the same cycle as an incoming instruction
    es2ms_valid = 1'b1; wb_ex = 1'b1;
    es2ms_bus = {32'h300, 3'b001, 32'h77, 5'b00100, 5'd11, 1'b1, 16'h0001};
    cyc();
    es2ms_valid = 1'b0; wb_ex = 1'b0;
    #1;
    chk("flush.valid", 128'(ms2ws_valid), 128'(1'b0));
    chk("flush.ex", 128'(ms_ex), 128'(1'b0));
    chk("flush.allowin", 128'(ms_allowin), 128'(1'b1));

    // Asynchronous reset during a WB stall, then immediate acceptance
    es2ms_valid = 1'b1; ws_allowin = 1'b0;
    es2ms_bus = {32'h400, 3'b001, 32'h0, 5'b00100, 5'd12, 1'b1, 16'h0};
    cyc();
    es2ms_valid = 1'b0;
    cyc();
    #1;
    chk("arst.pre", 128'(ms2ws_valid), 128'(1'b1));
    resetn = 1'b0;
    #1;
    chk("arst.valid", 128'(ms2ws_valid), 128'(1'b0));
    chk("arst.allowin", 128'(ms_allowin), 128'(1'b1));
    @(negedge clk);
    resetn = 1'b1;
    es2ms_valid = 1'b1;
    es2ms_bus = {32'h500, 3'b001, 32'h0, 5'b00100, 5'd13, 1'b1, 16'h0};
    cyc();
    es2ms_valid = 1'b0;
    data_sram_rdata = 32'hCAFE_F00D;
    #1;
    chk("arst.accept", 128'(ms2ws_valid), 128'(1'b1));
    chk("arst.bus", 128'(ms2ws_bus), 128'({32'h500, 32'hCAFE_F00D, 5'd13, 1'b1, 16'h0}));
    ws_allowin = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
